// File: rtl/ifetch_pkg.sv
// Shared fetch-stage types and constants; RESET_PC is also used by the PC register.
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ifetch_slot.sv
// One-entry instruction slot for decode: capture or consume each cycle, flush wins.
// Zero-latency free indication (empty or being consumed); fault bit exists only with IFETCH_MISALIGN_CHECK_EN.
module ifetch_slot
    import ifetch_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_flush,
    input  logic            i_capture,
    input  logic [ILEN-1:0] i_cap_inst,
    input  logic [XLEN-1:0] i_cap_pc,
`ifdef IFETCH_MISALIGN_CHECK_EN
    input  logic            i_cap_fault,
    output logic            o_fault,
`endif
    input  logic            i_consume,
    output logic            o_valid,
    output logic            o_free,
    output logic [ILEN-1:0] o_inst,
    output logic [XLEN-1:0] o_pc
);

    logic            r_valid;
    logic [ILEN-1:0] r_inst;
    logic [XLEN-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_inst  <= ILEN'(NOP_INST);
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_capture) begin
            r_valid <= 1'b1;
            r_inst  <= i_cap_inst;
            r_pc    <= i_cap_pc;
        end else if (i_consume) begin
            r_valid <= 1'b0;
        end
    end

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic r_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (!i_flush && i_capture) begin
            r_fault <= i_cap_fault;
        end
    end

    assign o_fault = r_fault;
`endif

    assign o_valid = r_valid;
    assign o_free  = !r_valid || i_consume;
    assign o_inst  = r_inst;
    assign o_pc    = r_pc;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: one outstanding imem request, result registered into a one-entry slot.
// Fire-to-slot latency is response delay + 1; stalls the PC unless a request fires (or, with IFETCH_MISALIGN_CHECK_EN, a fault is captured).
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    input  logic            redirect,
    output logic            fetch_stall,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst_out,
`ifdef IFETCH_MISALIGN_CHECK_EN
    output logic            inst_fault,
`endif
    output logic [XLEN-1:0] inst_pc
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_req_pc;

    logic            w_slot_free;
    logic            w_req_ok;
    logic            w_misaligned;
    logic            w_fire;
    logic            w_fault_cap;
    logic            w_resp_take;
    logic            w_capture;
    logic [ILEN-1:0] w_cap_inst;
    logic [XLEN-1:0] w_cap_pc;

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign w_misaligned = (pc_in[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_req_ok       = (r_state == ST_REQ) && w_slot_free && !redirect;
    assign imem_req_valid = w_req_ok && !w_misaligned;
    assign imem_req_addr  = pc_in;
    assign w_fire         = imem_req_valid && imem_req_ready;
    assign w_fault_cap    = w_req_ok && w_misaligned;
    assign fetch_stall    = !(w_fire || w_fault_cap);

    // A response coincident with a redirect belongs to the flushed path.
    assign w_resp_take = (r_state == ST_WAIT) && imem_resp_valid && !redirect;
    assign w_capture   = w_resp_take || w_fault_cap;
    assign w_cap_inst  = w_fault_cap ? ILEN'(NOP_INST) : imem_resp_data;
    assign w_cap_pc    = w_fault_cap ? pc_in : r_req_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_req_pc <= '0;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_REQ;
                ST_REQ: begin
                    if (w_fire) begin
                        r_state  <= ST_WAIT;
                        r_req_pc <= pc_in;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) r_state <= ST_REQ;
                    else if (redirect)   r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (imem_resp_valid) r_state <= ST_REQ;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    ifetch_slot #(
        .XLEN(XLEN),
        .ILEN(ILEN)
    ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (redirect),
        .i_capture  (w_capture),
        .i_cap_inst (w_cap_inst),
        .i_cap_pc   (w_cap_pc),
`ifdef IFETCH_MISALIGN_CHECK_EN
        .i_cap_fault(w_fault_cap),
        .o_fault    (inst_fault),
`endif
        .i_consume  (inst_ready),
        .o_valid    (inst_valid),
        .o_free     (w_slot_free),
        .o_inst     (inst_out),
        .o_pc       (inst_pc)
    );

    // A response with nothing outstanding indicates a broken memory model.
    a_no_stray_resp: assert property (@(posedge clk) disable iff (rst)
        !(imem_resp_valid && ((r_state == ST_IDLE) || (r_state == ST_REQ))));

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;
    import ifetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_in;
    logic        redirect;
    logic        fetch_stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [63:0] inst_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
    logic        inst_fault;
`endif

    always #5 clk = ~clk;

    ifetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .redirect       (redirect),
        .fetch_stall    (fetch_stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
`ifdef IFETCH_MISALIGN_CHECK_EN
        .inst_fault     (inst_fault),
`endif
        .inst_pc        (inst_pc)
    );

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] inst, input logic [63:0] pc);
        exp_t e;
        e.inst = inst;
        e.pc   = pc;
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor: every slot handoff to decode must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && inst_valid && inst_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got inst %h pc %h expected no instruction", inst_out, inst_pc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_inst", {32'h0, inst_out}, {32'h0, e.inst});
                check("sb_pc", inst_pc, e.pc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        pc_in           = RESET_PC;
        redirect        = 1'b0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        inst_ready      = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
        check("rst_inst_out", {32'h0, inst_out}, 64'h13);
        check("rst_inst_pc", inst_pc, 64'h0);
        check("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        check("rst_fetch_stall", {63'h0, fetch_stall}, 64'h1);
`ifdef IFETCH_MISALIGN_CHECK_EN
        check("rst_inst_fault", {63'h0, inst_fault}, 64'h0);
`endif

        // Cycle 0 after reset: IDLE, no request.
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_valid", {63'h0, imem_req_valid}, 64'h0);
        check("idle_stall", {63'h0, fetch_stall}, 64'h1);

        // Cycle 1: REQ, request fires at the end of it.
        tick();
        @(negedge clk);
        check("first_req_valid", {63'h0, imem_req_valid}, 64'h1);
        check("first_req_addr", imem_req_addr, 64'h8000_0000);
        check("first_stall", {63'h0, fetch_stall}, 64'h0);

        tick();
        pc_in           = 64'h8000_0004;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0000_0513;
        push_exp(32'h0000_0513, 64'h8000_0000);
        @(negedge clk);
        check("wait_req_valid", {63'h0, imem_req_valid}, 64'h0);
        check("wait_stall", {63'h0, fetch_stall}, 64'h1);
        check("wait_inst_valid", {63'h0, inst_valid}, 64'h0);

        tick();
        imem_resp_valid = 1'b0;
        @(negedge clk);
        check("cap_inst_valid", {63'h0, inst_valid}, 64'h1);
        check("cap_inst_out", {32'h0, inst_out}, 64'h0000_0513);
        check("cap_inst_pc", inst_pc, 64'h8000_0000);

        // Decode stalled for 5 cycles: slot holds, no request, PC held.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_req_valid", {63'h0, imem_req_valid}, 64'h0);
            check("bp_stall", {63'h0, fetch_stall}, 64'h1);
            check("bp_inst_out", {32'h0, inst_out}, 64'h0000_0513);
            check("bp_inst_valid", {63'h0, inst_valid}, 64'h1);
            tick();
        end
        inst_ready = 1'b1;
        @(negedge clk);
        check("release_req_valid", {63'h0, imem_req_valid}, 64'h1);
        check("release_stall", {63'h0, fetch_stall}, 64'h0);
        check("release_req_addr", imem_req_addr, 64'h8000_0004);

        tick();
        pc_in           = 64'h8000_0008;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0010_0093;
        imem_req_ready  = 1'b0;
        push_exp(32'h0010_0093, 64'h8000_0004);
        tick();
        imem_resp_valid = 1'b0;

        // Memory not ready for 3 cycles: request held with a stable address.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("nrdy_req_valid", {63'h0, imem_req_valid}, 64'h1);
            check("nrdy_req_addr", imem_req_addr, 64'h8000_0008);
            check("nrdy_stall", {63'h0, fetch_stall}, 64'h1);
            tick();
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        check("rdy_stall", {63'h0, fetch_stall}, 64'h0);
        tick();
        pc_in = 64'h8000_000C;

        // Redirect while waiting; stale response 3 cycles later is dropped.
        redirect = 1'b1;
        @(negedge clk);
        check("redir_req_valid", {63'h0, imem_req_valid}, 64'h0);
        tick();
        redirect = 1'b0;
        pc_in    = 64'h8000_0100;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("drain_req_valid", {63'h0, imem_req_valid}, 64'h0);
            check("drain_stall", {63'h0, fetch_stall}, 64'h1);
            tick();
        end
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        tick();
        imem_resp_valid = 1'b0;
        @(negedge clk);
        check("drop_inst_valid", {63'h0, inst_valid}, 64'h0);
        check("target_req_valid", {63'h0, imem_req_valid}, 64'h1);
        check("target_req_addr", imem_req_addr, 64'h8000_0100);
        tick();
        pc_in = 64'h8000_0104;

        // Redirect coincident with the response.
        redirect        = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h1234_5678;
        tick();
        redirect        = 1'b0;
        imem_resp_valid = 1'b0;
        pc_in           = 64'h8000_0200;
        @(negedge clk);
        check("coinc_inst_valid", {63'h0, inst_valid}, 64'h0);
        check("coinc_req_valid", {63'h0, imem_req_valid}, 64'h1);
        check("coinc_req_addr", imem_req_addr, 64'h8000_0200);
        tick();
        pc_in           = 64'h8000_0204;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hABCD_E037;
        imem_req_ready  = 1'b0;
        push_exp(32'hABCD_E037, 64'h8000_0200);
        tick();
        imem_resp_valid = 1'b0;
        @(negedge clk);
        check("tgt_inst_valid", {63'h0, inst_valid}, 64'h1);
        check("tgt_inst_pc", inst_pc, 64'h8000_0200);
        tick();
        pc_in      = 64'h8000_0002;
        inst_ready = 1'b0;
        @(negedge clk);
        check("consumed_inst_valid", {63'h0, inst_valid}, 64'h0);
`ifdef IFETCH_MISALIGN_CHECK_EN
        check("mis_req_valid", {63'h0, imem_req_valid}, 64'h0);
        check("mis_stall", {63'h0, fetch_stall}, 64'h0);
        tick();
        pc_in = 64'h8000_0100;
        @(negedge clk);
        check("mis_inst_valid", {63'h0, inst_valid}, 64'h1);
        check("mis_inst_fault", {63'h0, inst_fault}, 64'h1);
        check("mis_inst_pc", inst_pc, 64'h8000_0002);
        check("mis_inst_out", {32'h0, inst_out}, 64'h13);
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("mis_flush_valid", {63'h0, inst_valid}, 64'h0);
`else
        check("nochk_req_valid", {63'h0, imem_req_valid}, 64'h1);
        check("nochk_req_addr", imem_req_addr, 64'h8000_0002);
        check("nochk_stall", {63'h0, fetch_stall}, 64'h1);
`endif

        tick();
        tick();
        check("sb_leftover", 64'(sb_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage sitting directly downstream of the PC register. It takes the current fetch address, issues one instruction-memory request at a time, and registers the returned 32-bit instruction with its PC into a one-entry output slot for decode. It drives a stall signal back to the PC register, which holds the PC whenever the fetch stage cannot accept a new address. Redirects (branch or exception) flush the slot and discard any in-flight response.

## Interface
- `XLEN`, 64, address/PC width
- `ILEN`, 32, instruction width

- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `pc_in` in XLEN: current PC from the PC register
- `redirect` in 1: branch or exception taken this cycle; flush
- `fetch_stall` out 1: PC must hold; deasserted only in a request-accept cycle
- `imem_req_valid` out 1: request valid
- `imem_req_ready` in 1: memory accepts request
- `imem_req_addr` out XLEN: request address, equals `pc_in` combinationally
- `imem_resp_valid` in 1: response valid; one per accepted request, at least 1 cycle later
- `imem_resp_data` in ILEN: returned instruction
- `inst_valid` out 1: output slot full
- `inst_ready` in 1: decode consumes the slot
- `inst_out` out ILEN: instruction
- `inst_pc` out XLEN: PC of `inst_out`
- `inst_fault` out 1: instruction-address-misaligned fault; only present with the macro

## Operation
- FSM states:
  - IDLE: after reset; always goes to REQ on the next cycle.
  - REQ: request may issue.
  - WAIT: one request outstanding.
  - DRAIN: one stale request outstanding; its response is dropped.
- `slot_free` = !`inst_valid` || `inst_ready`.
- `imem_req_valid` = (state==REQ) && `slot_free` && !`redirect` && !misaligned.
- Request fire (valid && ready):
  - latch `pc_in` into `req_pc`; go to WAIT.
  - `fetch_stall` = 0 this cycle only, so the PC register advances by 4.
- WAIT + `imem_resp_valid`:
  - slot <= {1, `imem_resp_data`, `req_pc`}; go to REQ.
  - The slot is guaranteed free at this point: only one request is outstanding, and it was issued only when `slot_free` held.
- WAIT + `redirect` without a response: go to DRAIN.
- WAIT + `redirect` with a response in the same cycle: drop the response and go to REQ.
- DRAIN + `imem_resp_valid`: drop the response; go to REQ.
- `redirect` in any state:
  - `inst_valid` <= 0 (overrides `inst_ready` and any capture).
  - No request is issued that cycle; the next cycle fetches the redirect target.
- Slot handshake:
  - `inst_ready` && `inst_valid` with no new capture: `inst_valid` <= 0.
  - Capture and consume in the same cycle: new data replaces old.
- `inst_out`/`inst_pc` hold their value while `inst_valid` && !`inst_ready`.
- `fetch_stall` is 1 in every cycle except request fire (and, with the macro, fault capture). `redirect` takes priority in the PC register regardless.

## Timing
- Reset values (all outputs): `inst_valid`/`inst_fault` 0, `inst_out` 32'h0000_0013, `inst_pc` 0, `imem_req_valid` 0, `fetch_stall` 1. State = IDLE, `req_pc` = 0.
- First request: cycle 2 after `rst` falls (IDLE takes 1 cycle).
- Latency:
  - request fire at T, response at T+k (k≥1) → `inst_valid` at T+k+1.
  - Best-case throughput: one instruction per 2 cycles.
- `rst` mid-transaction: state returns to IDLE and a pending response is ignored. The memory side is reset together with this block.
- An `imem_resp_valid` arriving in REQ or IDLE is a protocol error: ignored, and a simulation assertion fires.

## Configuration
- `IFETCH_MISALIGN_CHECK_EN` defined:
  - In REQ with `slot_free`, !`redirect`, and `pc_in`[1:0] != 0: no memory request issued.
  - Slot <= {valid=1, `inst_fault`=1, `inst_out`=NOP, `inst_pc`=`pc_in`}; `fetch_stall`=0 that cycle.
  - State stays REQ. Decode raises the exception, which arrives here as `redirect`.
- Undefined: `inst_fault` port absent; `pc_in`[1:0] ignored; address issued unchanged.

## Structure
- `ifetch_pkg` holds:
  - state enum (IDLE, REQ, WAIT, DRAIN)
  - `NOP_INST` = 32'h0000_0013
  - `RESET_PC` = 64'h0000_0000_8000_0000, shared with the PC register.
- Sub-module `ifetch_slot`: one-entry valid/ready register with flush, capture and consume inputs. The FSM and request logic stay in `ifetch_unit`.

## Test plan
- Reset, then `pc_in`=0x8000_0000 with memory ready and responding after 1 cycle with 0x0000_0513:
  - req fires in cycle 2;
  - `inst_valid` with `inst_out`=0x0000_0513, `inst_pc`=0x8000_0000 two cycles later;
  - `fetch_stall` low only in the fire cycle.
- `inst_ready`=0 for 5 cycles with a full slot: no new request issues, `fetch_stall`=1, outputs stable; release → next request fires the same cycle.
- `imem_req_ready` low for 3 cycles: `imem_req_valid` held, `imem_req_addr` stable, `fetch_stall`=1 throughout.
- `redirect` in WAIT, response 3 cycles later with 0xDEADBEEF:
  - response dropped, `inst_valid` stays 0;
  - next request uses the target `pc_in` 0x8000_0100.
- `redirect` coincident with the response: response dropped; FSM in REQ on the next cycle.
- With `IFETCH_MISALIGN_CHECK_EN`, `pc_in`=0x8000_0002:
  - no `imem_req_valid`;
  - `inst_valid`=1, `inst_fault`=1, `inst_pc`=0x8000_0002, `inst_out`=0x0000_0013 on the next cycle.
